// File: rtl/pid_plant_model.sv
// pid_plant_model
// ---------------
// First-order plant emulator used to close the loop around pid_controller.
// Every TICK_DIV enabled clocks the model runs one update:
//   SAMPLE    - capture control_in, push it through a DELAY-deep transport
//               delay line and take the oldest entry as the drive value u
//   INTEGRATE - first-order lag on an unsigned 8.8 state:
//               y <= y + ((u << 8) - y) >>> SHIFT
//   OUTPUT    - feedback <= clamp(y[15:8] + disturbance, 0, 255), pulse
//               sample_valid for one cycle
//
// Parameters:
//   TICK_DIV     clk cycles per plant update (4..255)
//   SHIFT        lag time constant, 2^SHIFT updates (0..7)
//   DELAY        transport delay in updates (0..15), 0 = no delay line
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   en           plant runs while high (gates the tick counter only)
//   control_in   unsigned actuator command
//   disturbance  signed load disturbance added to the output
//   feedback     unsigned measured value
//   sample_valid one-cycle pulse when feedback has just been updated
module pid_plant_model #(
    parameter int TICK_DIV = 16,
    parameter int SHIFT    = 2,
    parameter int DELAY    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] control_in,
    input  logic [7:0] disturbance,
    output logic [7:0] feedback,
    output logic       sample_valid
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SAMPLE    = 2'd1,
        INTEGRATE = 2'd2,
        OUTPUT    = 2'd3
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  tick_cnt_reg;
    logic        tick;
    logic [7:0]  delayed;
    logic [7:0]  u_reg;
    logic [15:0] y_reg;
    logic [15:0] y_next;
    logic signed [16:0] diff;
    logic signed [9:0]  out_sum;
    logic [7:0]  out_clamped;

    // Tick counter runs independently of the FSM; only en freezes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_reg <= '0;
        end else if (en) begin
            if (tick_cnt_reg == TICK_LAST) begin
                tick_cnt_reg <= '0;
            end else begin
                tick_cnt_reg <= tick_cnt_reg + 8'd1;
            end
        end
    end

    // With TICK_DIV >= 4 the FSM is always back in IDLE by the next tick,
    // so the IDLE qualifier never drops a tick in legal configurations.
    assign tick = en && (tick_cnt_reg == TICK_LAST) && (state_reg == IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: once started, an update runs to completion regardless of en.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (tick) state_next = SAMPLE;
            SAMPLE:    state_next = INTEGRATE;
            INTEGRATE: state_next = OUTPUT;
            OUTPUT:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Transport delay line. Stage 0 takes the new command; the last stage
    // holds the oldest command, which is what leaves the line on a shift.
    generate
        if (DELAY == 0) begin : g_no_delay
            assign delayed = control_in;
        end else begin : g_delay
            genvar gi;
            for (gi = 0; gi < DELAY; gi++) begin : g_stage
                logic [7:0] stage_reg;
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            stage_reg <= '0;
                        end else if (state_reg == SAMPLE) begin
                            stage_reg <= control_in;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            stage_reg <= '0;
                        end else if (state_reg == SAMPLE) begin
                            stage_reg <= g_stage[gi-1].stage_reg;
                        end
                    end
                end
            end
            assign delayed = g_stage[DELAY-1].stage_reg;
        end
    endgenerate

    // Lag step. The 17-bit signed difference covers -0xFFFF..+0xFF00; the
    // arithmetic shift floors toward -inf, so y converges from above and
    // below without leaving [0, 0xFFFF]; truncating the sum to 16 bits is exact.
    assign diff   = $signed({1'b0, u_reg, 8'h00}) - $signed({1'b0, y_reg});
    assign y_next = y_reg + 16'(diff >>> SHIFT);

    // Output: integer part of y plus signed disturbance, saturated to 0..255.
    assign out_sum = $signed({2'b00, y_reg[15:8]})
                   + $signed({{2{disturbance[7]}}, disturbance});

    always_comb begin
        out_clamped = out_sum[7:0];
        if (out_sum < 0) begin
            out_clamped = 8'd0;
        end else if (out_sum > 10'sd255) begin
            out_clamped = 8'd255;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            u_reg        <= '0;
            y_reg        <= '0;
            feedback     <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= (state_reg == OUTPUT);
            if (state_reg == SAMPLE) begin
                u_reg <= delayed;
            end
            if (state_reg == INTEGRATE) begin
                y_reg <= y_next;
            end
            if (state_reg == OUTPUT) begin
                feedback <= out_clamped;
            end
        end
    end

endmodule

// File: tb/tb_pid_plant_model.sv
// tb_pid_plant_model
// ------------------
// Two instances share all inputs: one without transport delay and one with
// DELAY=4. A per-instance reference model tracks enabled cycles, applies the
// plant equations in plain integer arithmetic and queues the expected feedback;
// a per-instance monitor pops and compares on every sample_valid pulse and
// checks that feedback holds and sample_valid stays low between pulses.
module tb_pid_plant_model;

    localparam int TD = 4;
    localparam int SH = 2;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] control_in;
    logic [7:0] disturbance;
    logic [7:0] fb [2];
    logic       sv [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_on = 1'b0;

    int obs_val [2][64];
    int obs_cyc [2][64];
    int obs_n   [2];
    int held    [2];
    int pend    [2];

    int start_c;
    int resume_c;
    int mx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int floor_div(int a, int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic chk(input string nm, input integer act, input integer exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_obs();
        obs_n[0] = 0;
        obs_n[1] = 0;
    endtask

    // Returns #1 after the first posedge at which at least n pulses were seen.
    task automatic wait_pulses(input int m, input int n);
        int budget;
        budget = n * TD * 2 + 20;
        for (int i = 0; i < budget && obs_n[m] < n; i++) @(posedge clk);
        #1;
        if (obs_n[m] < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_pulses dut%0d: saw %0d pulses, expected %0d", m, obs_n[m], n);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chk
            localparam int D = (gi == 0) ? 0 : 4;

            pid_plant_model #(
                .TICK_DIV(TD),
                .SHIFT   (SH),
                .DELAY   (D)
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .en          (en),
                .control_in  (control_in),
                .disturbance (disturbance),
                .feedback    (fb[gi]),
                .sample_valid(sv[gi])
            );

            int y_m     = 0;
            int ecnt    = 0;
            int mcyc    = 0;
            int samp_at = -1;
            int out_at  = -1;
            int cmds[$];
            int exp_q[$];

            // Reference model: a tick every TD enabled cycles, command taken one
            // cycle later, output three cycles later; commands reach the lag DELAY
            // updates after they were taken (zeros before that).
            always @(posedge clk) begin
                int k, u, d, s;
                if (rst) begin
                    y_m = 0; ecnt = 0; samp_at = -1; out_at = -1;
                    cmds.delete(); exp_q.delete();
                    pend[gi] = 0; held[gi] = 0;
                end else begin
                    if (mcyc == samp_at) begin
                        cmds.push_back(int'(control_in));
                        k = cmds.size();
                        u = (k > D) ? cmds[k - 1 - D] : 0;
                        y_m = y_m + floor_div(u * 256 - y_m, 1 << SH);
                    end
                    if (mcyc == out_at) begin
                        d = int'(disturbance);
                        if (d > 127) d = d - 256;
                        s = y_m / 256 + d;
                        if (s < 0) s = 0;
                        if (s > 255) s = 255;
                        exp_q.push_back(s);
                        pend[gi]++;
                    end
                    if (en) begin
                        ecnt++;
                        if (ecnt % TD == 0) begin
                            samp_at = mcyc + 1;
                            out_at  = mcyc + 3;
                        end
                    end
                end
                mcyc++;
            end

            always @(negedge clk) begin
                int e;
                if (mon_on) begin
                    if (sv[gi] === 1'b1) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_pulse dut%0d: feedback=%0d, no update expected", gi, fb[gi]);
                        end else begin
                            e = exp_q.pop_front();
                            pend[gi]--;
                            held[gi] = e;
                            if (fb[gi] !== e[7:0]) begin
                                n_fail++;
                                $display("FAIL pulse dut%0d: feedback=%0d, expected %0d", gi, fb[gi], e);
                            end else begin
                                $display("txn dut%0d cyc=%0d feedback=%0d", gi, cyc, fb[gi]);
                            end
                        end
                        if (obs_n[gi] < 64) begin
                            obs_val[gi][obs_n[gi]] = int'(fb[gi]);
                            obs_cyc[gi][obs_n[gi]] = cyc;
                        end
                        obs_n[gi]++;
                    end else begin
                        n_cmp++;
                        if (sv[gi] !== 1'b0 || fb[gi] !== held[gi][7:0]) begin
                            n_fail++;
                            $display("FAIL hold dut%0d: sample_valid=%b feedback=%0d, expected 0 / %0d",
                                     gi, sv[gi], fb[gi], held[gi]);
                        end
                    end
                end
            end
        end
    endgenerate

    initial begin
        rst = 1'b1; en = 1'b0; control_in = 8'hFF; disturbance = 8'h00;
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_feedback_d0", fb[0], 0);
        chk("reset_valid_d0", sv[0], 0);
        chk("reset_feedback_d4", fb[1], 0);
        chk("reset_valid_d4", sv[1], 0);

        // Step response with both delay settings
        control_in = 8'd200; rst = 1'b0; en = 1'b1; mon_on = 1'b1;
        start_c = cyc;
        wait_pulses(0, 40);
        chk("first_pulse_latency", obs_cyc[0][0] - start_c, TD + 3);
        chk("step_1", obs_val[0][0], 50);
        chk("step_2", obs_val[0][1], 87);
        chk("step_3", obs_val[0][2], 115);
        mx = 0;
        for (int i = 0; i < 40; i++) if (obs_val[0][i] > mx) mx = obs_val[0][i];
        chk("step_max_le_200", int'(mx <= 200), 1);
        chk("step_converged", int'(obs_val[0][39] >= 199 && obs_val[0][39] <= 200), 1);
        for (int i = 0; i < 4; i++) chk("delay_zero", obs_val[1][i], 0);
        chk("delay_5th", obs_val[1][4], 50);
        chk("delay_6th", obs_val[1][5], 87);

        // Saturation high, then low, then -1 at zero
        disturbance = 8'd100; clear_obs();
        wait_pulses(0, 3);
        chk("sat_high", obs_val[0][2], 255);
        control_in = 8'd50; disturbance = 8'h00; clear_obs();
        wait_pulses(0, 45);
        chk("settle_50", obs_val[0][44], 50);
        disturbance = 8'h9C; clear_obs();
        wait_pulses(0, 3);
        chk("sat_low", obs_val[0][2], 0);
        control_in = 8'd0; disturbance = 8'h00; clear_obs();
        wait_pulses(0, 45);
        disturbance = 8'hFF; clear_obs();
        wait_pulses(0, 3);
        chk("neg_one_at_zero", obs_val[0][2], 0);

        // Enable dropped in the INTEGRATE cycle for 10 cycles
        control_in = 8'd200; disturbance = 8'h00; clear_obs();
        wait_pulses(0, 1);
        @(posedge clk); #1;
        en = 1'b0; clear_obs();
        repeat (10) @(posedge clk);
        #1;
        chk("gated_one_pulse", obs_n[0], 1);
        clear_obs(); resume_c = cyc; en = 1'b1;
        wait_pulses(0, 1);
        chk("resume_spacing", obs_cyc[0][0] - resume_c, 6);

        // Reset in the INTEGRATE cycle
        clear_obs();
        wait_pulses(0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_feedback_d0", fb[0], 0);
        chk("midrst_valid_d0", sv[0], 0);
        chk("midrst_feedback_d4", fb[1], 0);
        chk("midrst_valid_d4", sv[1], 0);
        rst = 1'b0; clear_obs();
        wait_pulses(1, 6);
        for (int i = 0; i < 4; i++) chk("midrst_delay_zero", obs_val[1][i], 0);
        chk("midrst_delay_5th", obs_val[1][4], 50);
        chk("midrst_delay_6th", obs_val[1][5], 87);

        // Randomized stimulus
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            control_in  = 8'($urandom);
            disturbance = 8'($urandom);
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 149) == 0);
        end

        // Drain in-flight updates
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_d0", pend[0], 0);
        chk("drain_d4", pend[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
